// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB memory completer.
// Holds the FSM state enum and the byte-lane helpers.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STR = DATA_WIDTH_DEF / 8;

  // Byte lanes for a given data width.
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_WIDTH store: byte-enable write, registered read, async clear.
// Ports: clk, rst_n, we, be, widx, wdata, re, ridx, rdata.
module apb_mem_bank
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IW         = 6,
  parameter int NSTR       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [NSTR-1:0]       be,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NSTR; b++) begin
        if (be[b]) begin
          mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: PSEL decode, setup/access FSM, word memory.
// Ports: clk, reset (async low), PADDR/PWDATA/PSEL/PWRITE/PENABLE/PSTROBE in,
// PRDATA/PREADY out. Define APB_WAIT_EN to insert WAIT_CYCLES wait states.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL         = 4,
  parameter int SLV_IDX     = 0,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [SEL-1:0]            PSEL,
  input  logic                      PWRITE,
  input  logic                      PENABLE,
  input  logic [DATA_WIDTH/8-1:0]   PSTROBE,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY
);

  localparam int NSTR = lanes(DATA_WIDTH);
  localparam int OFF  = (NSTR > 1) ? $clog2(NSTR) : 0;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state;
  logic          sel;
  logic          setup;
  logic          wr_en;
  logic          rd_en;
  logic [IW-1:0] idx;
  logic          unused_bits;

  assign sel   = PSEL[SLV_IDX];
  assign idx   = PADDR[OFF +: IW];
  assign setup = sel & ~PENABLE;
  // Commit only on the completing edge of a selected access.
  assign wr_en = sel & PENABLE & PREADY & PWRITE
               & (state != IDLE);
  assign rd_en = setup & ~PWRITE;
  assign unused_bits = ^{PADDR, PSEL};

`ifdef APB_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 0)
                    ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WLOAD = CW'(WAIT_CYCLES);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      PREADY <= 1'b0;
`ifdef APB_WAIT_EN
      cnt    <= '0;
`endif
    end else if (!sel) begin
      state  <= IDLE;
      PREADY <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // PENABLE without a prior setup is ignored.
          if (!PENABLE) begin
            state  <= SETUP;
`ifdef APB_WAIT_EN
            cnt    <= WLOAD;
            PREADY <= (WLOAD == '0);
`else
            PREADY <= 1'b1;
`endif
          end
        end
        SETUP, ACCESS: begin
          if (!PENABLE) begin
            // A fresh setup restarts the transfer.
            state  <= SETUP;
`ifdef APB_WAIT_EN
            cnt    <= WLOAD;
            PREADY <= (WLOAD == '0);
`else
            PREADY <= 1'b1;
`endif
          end else if (PREADY) begin
            state  <= IDLE;
            PREADY <= 1'b0;
          end else begin
            state  <= ACCESS;
`ifdef APB_WAIT_EN
            cnt    <= cnt - 1'b1;
            PREADY <= (cnt <= 1);
`else
            PREADY <= 1'b1;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          PREADY <= 1'b0;
        end
      endcase
    end
  end

  apb_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW),
    .NSTR       (NSTR)
  ) u_bank (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_en),
    .be    (PSTROBE),
    .widx  (idx),
    .wdata (PWDATA),
    .re    (rd_en),
    .ridx  (idx),
    .rdata (PRDATA)
  );

endmodule
